// File: rtl/fifo_check_types.sv
// Shared types for the FIFO protocol checker: error codes and checker states.
package fifo_check_types;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_UNDERFLOW = 3'd1,
        ERR_OVERFLOW  = 3'd2,
        ERR_READY     = 3'd3,
        ERR_VALID     = 3'd4,
        ERR_DATA      = 3'd5
    } err_e;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_CHECK = 2'd1,
        S_FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/shadow_queue.sv
// Circular-buffer reference model of the FIFO under check; the caller decides
// which pushes and pops are legal, this block only stores and counts.
module shadow_queue #(
    parameter int WIDTH_P = 8,
    parameter int CAP_P   = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH_P-1:0]       data_i,
    output logic [WIDTH_P-1:0]       data_o,
    output logic [$clog2(CAP_P):0]   count_o
);

    localparam int PW = $clog2(CAP_P);
    localparam int CW = PW + 1;

    logic [WIDTH_P-1:0] mem [CAP_P];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count_q;

    // Storage carries no reset; the count alone decides what is meaningful.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Power-of-two capacity lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_i) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem[rd_ptr];
    assign count_o = count_q;

endmodule

// File: rtl/fifo_checker.sv
// Protocol checker for a valid/ready/yumi FIFO: shadows its contents and
// flags the first handshake or data violation with a sticky code.
module fifo_checker
    import fifo_check_types::*;
#(
    parameter int WIDTH_P = 8,
    parameter int CAP_P   = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   valid_i,
    input  logic [WIDTH_P-1:0]     data_i,
    input  logic                   ready_o_dut,
    input  logic                   valid_o_dut,
    input  logic [WIDTH_P-1:0]     data_o_dut,
    input  logic                   yumi_i,
    output logic                   err_o,
    output logic [2:0]             err_code_o,
    output logic [$clog2(CAP_P):0] occupancy_o,
    output logic [15:0]            enq_cnt_o,
    output logic [15:0]            deq_cnt_o,
    output logic [WIDTH_P-1:0]     expected_o
);

    localparam int CW = $clog2(CAP_P) + 1;
    localparam logic [CW-1:0] FULL_C = CW'(CAP_P);

    logic [CW-1:0]      count;
    logic [WIDTH_P-1:0] head;
    logic               is_empty;
    logic               is_full;
    logic               push;
    logic               pop;
    err_e               detected;
    state_e             state_q;
    err_e               err_code_q;

    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_C);
    // Illegal events leave the model untouched; a pop at full frees the slot.
    assign pop      = yumi_i && !is_empty;
    assign push     = valid_i && !(is_full && !yumi_i);

    always_comb begin
        detected = ERR_NONE;
        if (yumi_i && is_empty) begin
            detected = ERR_UNDERFLOW;
        end else if (valid_i && is_full && !yumi_i) begin
            detected = ERR_OVERFLOW;
        end else if (ready_o_dut != !is_full) begin
            detected = ERR_READY;
        end else if (valid_o_dut != !is_empty) begin
            detected = ERR_VALID;
        end else if (pop && (data_o_dut != head)) begin
            detected = ERR_DATA;
        end
    end

    shadow_queue #(
        .WIDTH_P (WIDTH_P),
        .CAP_P   (CAP_P)
    ) u_queue (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .pop_i     (pop),
        .data_i    (data_i),
        .data_o    (head),
        .count_o   (count)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_INIT;
            err_o      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            err_o <= 1'b0;
            case (state_q)
                S_INIT: begin
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (detected != ERR_NONE) begin
                        state_q    <= S_FAULT;
                        err_o      <= 1'b1;
                        err_code_q <= detected;
                    end
                end
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            enq_cnt_o <= '0;
            deq_cnt_o <= '0;
        end else begin
            if (push) begin
                enq_cnt_o <= enq_cnt_o + 1'b1;
            end
            if (pop) begin
                deq_cnt_o <= deq_cnt_o + 1'b1;
            end
        end
    end

    assign occupancy_o = count;
    assign expected_o  = is_empty ? '0 : head;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_fifo_checker.sv
// Bench for fifo_checker: directed scenarios plus random traffic, compared
// against a queue-based model of the checker's rules.
module tb_fifo_checker;
    import fifo_check_types::*;

    localparam int WIDTH_P = 8;
    localparam int CAP_P   = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         valid_i = 1'b0;
    logic [7:0]   data_i = '0;
    logic         ready_o_dut = 1'b0;
    logic         valid_o_dut = 1'b0;
    logic [7:0]   data_o_dut = '0;
    logic         yumi_i = 1'b0;
    logic         err_o;
    logic [2:0]   err_code_o;
    logic [4:0]   occupancy_o;
    logic [15:0]  enq_cnt_o;
    logic [15:0]  deq_cnt_o;
    logic [7:0]   expected_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    int m_enq;
    int m_deq;
    int m_code;
    bit m_active;
    bit m_fault;
    bit m_pulse;

    always #5 clk = ~clk;

    fifo_checker #(
        .WIDTH_P (WIDTH_P),
        .CAP_P   (CAP_P)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_o_dut (ready_o_dut),
        .valid_o_dut (valid_o_dut),
        .data_o_dut  (data_o_dut),
        .yumi_i      (yumi_i),
        .err_o       (err_o),
        .err_code_o  (err_code_o),
        .occupancy_o (occupancy_o),
        .enq_cnt_o   (enq_cnt_o),
        .deq_cnt_o   (deq_cnt_o),
        .expected_o  (expected_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_enq = 0;
        m_deq = 0;
        m_code = int'(ERR_NONE);
        m_active = 1'b0;
        m_fault = 1'b0;
        m_pulse = 1'b0;
    endtask

    // One clock edge of the checker's rules, written against a plain queue.
    task automatic model_step(input bit v, input logic [7:0] d, input bit y,
                              input bit rdy, input bit vld, input logic [7:0] dout);
        int occ;
        int code;
        occ = q.size();
        code = int'(ERR_NONE);
        m_pulse = 1'b0;
        if (m_active && !m_fault) begin
            if (y && occ == 0)                       code = int'(ERR_UNDERFLOW);
            else if (v && occ == CAP_P && !y)        code = int'(ERR_OVERFLOW);
            else if (rdy != (occ < CAP_P))           code = int'(ERR_READY);
            else if (vld != (occ != 0))              code = int'(ERR_VALID);
            else if (y && dout != q[0])              code = int'(ERR_DATA);
            if (code != int'(ERR_NONE)) begin
                m_fault = 1'b1;
                m_pulse = 1'b1;
                m_code = code;
            end
        end
        m_active = 1'b1;
        if (y && occ > 0) begin
            void'(q.pop_front());
            m_deq = (m_deq + 1) % 65536;
        end
        if (v && !(occ == CAP_P && !y)) begin
            q.push_back(d);
            m_enq = (m_enq + 1) % 65536;
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, ".err"},  32'(err_o),       32'(m_pulse));
        check({tag, ".code"}, 32'(err_code_o),  32'(m_code));
        check({tag, ".occ"},  32'(occupancy_o), 32'(q.size()));
        check({tag, ".enq"},  32'(enq_cnt_o),   32'(m_enq));
        check({tag, ".deq"},  32'(deq_cnt_o),   32'(m_deq));
        check({tag, ".head"}, 32'(expected_o),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
    endtask

    task automatic applyStimulus(input string tag, input bit v, input logic [7:0] d, input bit y,
                                 input bit rdy, input bit vld, input logic [7:0] dout);
        @(negedge clk);
        valid_i = v;
        data_i = d;
        yumi_i = y;
        ready_o_dut = rdy;
        valid_o_dut = vld;
        data_o_dut = dout;
        @(posedge clk);
        model_step(v, d, y, rdy, vld, dout);
        #1;
        check_output(tag);
    endtask

    // FIFO under check behaves correctly relative to the model.
    task automatic honest(input string tag, input bit v, input logic [7:0] d, input bit y);
        applyStimulus(tag, v, d, y, q.size() < CAP_P, q.size() != 0,
                      (q.size() != 0) ? q[0] : 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        valid_i = 1'b0;
        yumi_i = 1'b0;
        model_reset();
        #1;
        check_output("reset");
        @(negedge clk);
        reset_n = 1'b1;
        honest("init", 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int sent;
        int guard;
        bit v;
        bit y;
        bit rdy;
        bit vld;
        logic [7:0] dout;

        model_reset();

        // Simple in-order traffic.
        do_reset();
        honest("enq11", 1'b1, 8'h11, 1'b0);
        honest("enq22", 1'b1, 8'h22, 1'b0);
        honest("enq33", 1'b1, 8'h33, 1'b0);
        for (int i = 0; i < 3; i++) honest("deq", 1'b0, 8'h00, 1'b1);

        // Full, then simultaneous push and pop.
        do_reset();
        honest("fill0", 1'b1, 8'h00, 1'b0);
        for (int i = 1; i < CAP_P; i++) honest("fill", 1'b1, 8'(i * 3 + 1), 1'b0);
        honest("both_full", 1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < CAP_P - 1; i++) honest("drain", 1'b0, 8'h00, 1'b1);
        check("last_is_aa", 32'(expected_o), 32'h0000_00AA);
        honest("drain_last", 1'b0, 8'h00, 1'b1);

        // Underflow in the first checking cycle.
        do_reset();
        honest("underflow", 1'b0, 8'h00, 1'b1);
        honest("after_uf", 1'b0, 8'h00, 1'b0);

        // Data mismatch, then a later underflow must not disturb the code.
        do_reset();
        honest("enq05", 1'b1, 8'h05, 1'b0);
        applyStimulus("bad_data", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h06);
        honest("late_uf", 1'b0, 8'h00, 1'b1);
        honest("late_idle", 1'b1, 8'h44, 1'b0);

        // Ready asserted while full, then asynchronous reset mid-cycle.
        do_reset();
        for (int i = 0; i < CAP_P; i++) honest("fill_r", 1'b1, 8'(i + 8'h40), 1'b0);
        applyStimulus("ready_full", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, q[0]);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_output("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        honest("init2", 1'b0, 8'h00, 1'b0);

        // Interleaved traffic across pointer wrap.
        do_reset();
        sent = 0;
        guard = 0;
        while ((sent < 20 || q.size() != 0) && guard < 400) begin
            v = (sent < 20) && (q.size() < CAP_P) && ($urandom_range(0, 2) != 0);
            y = (q.size() > 2 || sent >= 20) && (q.size() != 0) && ($urandom_range(0, 1) != 0);
            honest("wrap", v, 8'(sent * 7 + 3), y);
            if (v) sent++;
            guard++;
        end
        check("wrap_enq", 32'(enq_cnt_o), 32'd20);
        check("wrap_deq", 32'(deq_cnt_o), 32'd20);

        // Unconstrained random traffic with occasional misbehaving FIFO outputs.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            for (int i = 0; i < 60; i++) begin
                v = $urandom_range(0, 1) != 0;
                y = $urandom_range(0, 1) != 0;
                rdy = q.size() < CAP_P;
                vld = q.size() != 0;
                dout = (q.size() != 0) ? q[0] : 8'h00;
                if ($urandom_range(0, 31) == 0) rdy = !rdy;
                if ($urandom_range(0, 31) == 0) vld = !vld;
                if ($urandom_range(0, 15) == 0) dout = dout ^ 8'h01;
                applyStimulus("rand", v, 8'($urandom), y, rdy, vld, dout);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_checker.md
FIFO_CHECKER -- requirements
Module: fifo_checker

Interface
REQ-001 Parameter WIDTH_P, 8, data word width in bits.
REQ-002 Parameter CAP_P, 16, modelled FIFO capacity in words; power of two, at least 2.
REQ-003 clk_i  input  1  single clock; every register samples on posedge.
REQ-004 reset_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 valid_i  input  1  producer offers a word to the FIFO under check.
REQ-006 data_i  input  WIDTH_P  producer word.
REQ-007 ready_o_dut  input  1  ready indication from the FIFO under check.
REQ-008 valid_o_dut  input  1  valid indication from the FIFO under check.
REQ-009 data_o_dut  input  WIDTH_P  head word from the FIFO under check.
REQ-010 yumi_i  input  1  consumer takes the head word.
REQ-011 err_o  output  1  one-cycle pulse on the first detected error.
REQ-012 err_code_o  output  3  sticky code of the first error (err_e).
REQ-013 occupancy_o  output  $clog2(CAP_P)+1  current model word count.
REQ-014 enq_cnt_o, deq_cnt_o  output  16 each  accepted enqueue and dequeue counts; wrap modulo 2^16.
REQ-015 expected_o  output  WIDTH_P  model head word; 0 when the model is empty.

Function
REQ-016 Enqueue event = valid_i high at posedge; dequeue event = yumi_i high at posedge; both in the same cycle = BOTH.
REQ-017 The model SHALL be a circular buffer with wrapping read/write pointers; pointer wrap from CAP_P-1 to 0 needs no extra cycle.
REQ-018 States S_INIT, S_CHECK, S_FAULT. S_INIT is entered on reset and lasts one cycle with no checks. S_CHECK runs all checks. The first error moves S_CHECK to S_FAULT. S_FAULT is sticky until reset.
REQ-019 The check priority in S_CHECK (first match wins) SHALL be: UNDERFLOW, OVERFLOW, READY, VALID, DATA.
REQ-020 UNDERFLOW: yumi_i while occupancy is 0.
REQ-021 OVERFLOW: valid_i while occupancy equals CAP_P and yumi_i is low. BOTH at full is legal.
REQ-022 READY: ready_o_dut differs from (occupancy < CAP_P).
REQ-023 VALID: valid_o_dut differs from (occupancy != 0).
REQ-024 DATA: yumi_i with occupancy > 0 and data_o_dut differs from the model head.
REQ-025 err_o SHALL assert in the cycle after the offending posedge, for exactly one cycle; err_code_o latches in the same cycle.
REQ-026 The model SHALL keep tracking events in S_FAULT. An illegal event SHALL NOT change the model: an underflow pops nothing and an overflow pushes nothing.
REQ-027 On BOTH with occupancy > 0, the model SHALL pop and push in one cycle and occupancy SHALL stay unchanged.
REQ-028 On BOTH with occupancy 0, the event SHALL be flagged UNDERFLOW and the push SHALL still occur.
REQ-029 Counters SHALL increment only on legal accepted events.

Reset
REQ-030 While reset_n_i is low: state S_INIT, pointers, occupancy_o, enq_cnt_o, deq_cnt_o, expected_o and err_o all 0, err_code_o ERR_NONE.
REQ-031 Reset asserted mid-operation SHALL discard all model contents immediately, without waiting for a clock edge.
REQ-032 The model storage array itself needs no reset.

Structure
REQ-033 err_e (ERR_NONE, ERR_UNDERFLOW, ERR_OVERFLOW, ERR_READY, ERR_VALID, ERR_DATA) and the state enum SHALL live in the shared package fifo_check_types.
REQ-034 The circular buffer SHALL be the sub-module shadow_queue: push/pop/data/count ports, and the same clock and reset names.
REQ-035 The check logic and the state machine SHALL live in fifo_checker.

Verification
REQ-036 Reset, then enqueue 0x11, 0x22, 0x33, then 3 dequeues with the DUT returning the same words -> no err_o; enq_cnt_o=3, deq_cnt_o=3, occupancy_o=0.
REQ-037 Fill to 16 words, then BOTH with data_i=0xAA and head 0x00 -> no error; occupancy_o stays 16; the last dequeue returns 0xAA.
REQ-038 yumi_i in the first check cycle with the model empty -> err_o pulses one cycle later; err_code_o=ERR_UNDERFLOW; occupancy_o=0.
REQ-039 Enqueue 0x05, DUT presents 0x06 on yumi_i -> ERR_DATA; a later underflow leaves err_code_o at ERR_DATA and err_o stays low.
REQ-040 Model holds 16 words, ready_o_dut=1 -> ERR_READY. Assert reset_n_i low between clock edges -> all outputs read 0 before the next posedge.
REQ-041 Enqueue 20 words and dequeue them interleaved -> pointer wrap is exercised; data stays in order; no error.
